netwalk_dpl_egress_packer: RTL and testbench
============================================

Name: netwalk_dpl_egress_packer

Overview:
- Parametrised, back-pressure-aware successor of the dataplane egress serialiser.
- Captures each dataplane-core result bundle into a small result queue: header, table-miss flag, flow address, flow tag and flow count.
- Emits each result as one metadata beat followed by PAYLOAD_BEATS header beats into the egress packet FIFO.
- Honours FIFO full, counts emitted and dropped results, and sits between netwalk_dataplane_core_wrapper and the egress FIFO.

Parameters:
- DPL_PKT_BIT_WIDTH, 608, header width from the core.
- FIFO_DATA_WIDTH, 512, egress beat width (W).
- PAYLOAD_BEATS, 1, header beats per result; payload covers header bits [PAYLOAD_BEATS*W-1:0].
- OF_FLOW_TAG_WIDTH, 5, flow tag width (at most 8).
- TCAM_ADDR_WIDTH, 6, flow address width (at most 8).
- METER_COUNTER_SIZE, 32, flow count width.
- QUEUE_DEPTH, 4, result queue entries (power of 2, at least 2).
- BEAT_MARKER, 32'hcccccccc, metadata framing marker.

Ports:
- dpl_clk  in  1  sole clock.
- dpl_reset  in  1  synchronous reset, active-high.
- dpl_pkt_header_out_i  in  DPL_PKT_BIT_WIDTH  result header.
- dpl_pkt_header_out_enable_i  in  1  result valid, single-cycle strobe, no ready.
- dpl_of_table_missed_i  in  1  miss flag.
- dpl_flow_addr_i  in  TCAM_ADDR_WIDTH  matched entry.
- dpl_flow_tag_i  in  OF_FLOW_TAG_WIDTH  flow tag.
- dpl_flow_count_i  in  METER_COUNTER_SIZE  flow counter.
- egress_dpl_data_o  out  FIFO_DATA_WIDTH  beat data.
- egress_dpl_wr_en_o  out  1  beat write strobe.
- egress_dpl_full_i  in  1  egress FIFO full.
- egr_pkt_count_o  out  32  results fully emitted (saturating).
- egr_drop_count_o  out  32  results dropped on queue overflow (saturating).
- egr_queue_level_o  out  $clog2(QUEUE_DEPTH+1)  queue occupancy.
- egr_busy_o  out  1  queue non-empty or emission in progress.

Behaviour:
- Reset: the cycle after dpl_reset is sampled high, the queue is empty, beat index is 0, both counters are 0, and egr_busy_o is 0. egress_dpl_wr_en_o is combinationally forced to 0 while dpl_reset is high, including mid-packet; a partially sent packet is abandoned.
- Capture: on enable_i, the bundle is pushed in the same cycle if level<QUEUE_DEPTH, or if a pop occurs that cycle. Otherwise the bundle is discarded and drop_count increments.
- Emission FSM:
  - States: IDLE → META → PAY → back to META if the queue is still non-empty, else IDLE.
  - The beat index runs 0..PAYLOAD_BEATS.
  - IDLE → META: in the cycle after the queue becomes non-empty (push-to-first-write latency is 1 cycle).
  - Beat presentation: in META/PAY, egress_dpl_data_o shows the current beat from the queue head (combinational mux), and egress_dpl_wr_en_o = !egress_dpl_full_i && !dpl_reset.
  - A beat advances only when it is written (wr_en=1). While full is high the state, beat index and data hold.
  - Pop: on the last payload beat written, the head pops and pkt_count increments, in the same cycle. With no stall, beats are back-to-back with no idle cycle between results.
- Metadata beat (W=512 default; offsets derived generically):
  - [31:0] BEAT_MARKER.
  - [HU+31:32] header bits [DPL_PKT_BIT_WIDTH-1:PAYLOAD_BEATS*W], where HU = DPL_PKT_BIT_WIDTH-PAYLOAD_BEATS*W (default 96).
  - Next 32 bits: flow_count, zero-extended to 32.
  - Next 8 bits: tag, zero-extended.
  - Next 8 bits: addr, zero-extended.
  - Next 1 bit: missed.
  - Zeros above, then [W-1:W-32] BEAT_MARKER.
- Payload beat k = header[k*W +: W].
- Elaboration error if HU<0 or if the metadata fields overlap the top marker.
- Counters saturate at 32'hffffffff. egr_queue_level_o and the counters are registered.

Decomposition:
- Package netwalk_dpl_pkg: BEAT_MARKER default, metadata field offsets and widths as localparam functions of the parameters, and the result-bundle packed struct.
- Sub-module netwalk_egr_result_fifo: synchronous FIFO (QUEUE_DEPTH × bundle width) with push, pop, level, and simultaneous push/pop at full.

Test Plan:
- Single result: hdr=608'h{96'hA5..,512'h1234}, miss=1, addr=6'h2A, tag=5'h13, count=32'd7, full=0 → two writes on consecutive cycles: beat0 with marker at both ends, [127:32]=hdr top, [159:128]=7, [167:160]=8'h13, [175:168]=8'h2A, [176]=1; beat1 = 512'h1234; pkt_count=1.
- Back-pressure: full high for 5 cycles mid-packet → wr_en low for those cycles, data stable, no beat lost or duplicated.
- Overflow: 6 strobes on consecutive cycles while full=1, QUEUE_DEPTH=4 → level=4, drop_count=2; after full is released, 8 beats emitted in order, pkt_count=4.
- Push at full with a simultaneous pop → level stays 4, drop_count unchanged.
- Reset asserted after the metadata beat of a packet → wr_en=0 during reset; next cycle level=0, counters=0, busy=0; a new result emits cleanly starting with its metadata beat.
- PAYLOAD_BEATS=2, DPL_PKT_BIT_WIDTH=1100 → 3 beats per result, HU=76, payload order header[511:0] then header[1023:512].

Source files
------------

// File: rtl/netwalk_dpl_pkg.sv
// Shared types, constants and metadata-beat layout helpers for the egress packer.
// Latency: none; this file holds only definitions.
// Backpressure: none; this file holds only definitions.
package netwalk_dpl_pkg;

   localparam logic [31:0] BEAT_MARKER_DEFAULT = 32'hcccccccc;

   // Field widths inside the metadata beat (sideband values are zero-extended)
   localparam int MARKER_W = 32;
   localparam int COUNT_W  = 32;
   localparam int TAG_W    = 8;
   localparam int ADDR_W   = 8;

   // Sideband part of a captured result, already widened to metadata field sizes
   typedef struct packed {
      logic              missed;
      logic [ADDR_W-1:0] addr;
      logic [TAG_W-1:0]  tag;
      logic [COUNT_W-1:0] count;
   } egr_result_t;

   // Header bits that do not fit in the payload beats travel in the metadata beat
   function automatic int hdr_upper_w(input int pkt_w, input int beats, input int beat_w);
      return pkt_w - beats * beat_w;
   endfunction

   function automatic int meta_hdr_lo();
      return MARKER_W;
   endfunction

   function automatic int meta_count_lo(input int hu);
      return MARKER_W + hu;
   endfunction

   function automatic int meta_tag_lo(input int hu);
      return meta_count_lo(hu) + COUNT_W;
   endfunction

   function automatic int meta_addr_lo(input int hu);
      return meta_tag_lo(hu) + TAG_W;
   endfunction

   function automatic int meta_miss_bit(input int hu);
      return meta_addr_lo(hu) + ADDR_W;
   endfunction

   // First bit above the last metadata field; must not reach the top marker
   function automatic int meta_end(input int hu);
      return meta_miss_bit(hu) + 1;
   endfunction

endpackage

// File: rtl/netwalk_egr_result_fifo.sv
// Result queue: DEPTH entries of WIDTH bits, head visible combinationally.
// Latency: a pushed entry is visible at head (and counted in level) the next cycle.
// Backpressure: a push is refused only when full and no pop occurs in the same cycle.
module netwalk_egr_result_fifo #(
   parameter int WIDTH   = 8,
   parameter int DEPTH   = 4,
   parameter int LEVEL_W = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  logic               pop,
   input  logic [WIDTH-1:0]   din,
   output logic [WIDTH-1:0]   head,
   output logic               accepted,
   output logic [LEVEL_W-1:0] level
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_err
      $error("netwalk_egr_result_fifo: DEPTH must be a power of two and at least 2");
   end

   // A full queue still takes a new entry when the head leaves in the same cycle
   assign accepted = push && ((level != LEVEL_W'(DEPTH)) || pop);
   assign head     = mem[rd_ptr];

   // Storage write; contents need no reset because level gates their use
   always_ff @(posedge clk) begin
      if (accepted) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally on power-of-two depth
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (accepted) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (accepted && !pop) begin
            level <= level + LEVEL_W'(1);
         end else if (!accepted && pop) begin
            level <= level - LEVEL_W'(1);
         end
      end
   end

endmodule

// File: rtl/netwalk_dpl_egress_packer.sv
// Queues dataplane results and serialises each as one metadata beat plus PAYLOAD_BEATS header beats.
// Latency: first beat is written the cycle after capture; results stream back-to-back without stalls.
// Backpressure: egress full holds the current beat; queue overflow drops new results and counts them.
module netwalk_dpl_egress_packer
   import netwalk_dpl_pkg::*;
#(
   parameter int          DPL_PKT_BIT_WIDTH  = 608,
   parameter int          FIFO_DATA_WIDTH    = 512,
   parameter int          PAYLOAD_BEATS      = 1,
   parameter int          OF_FLOW_TAG_WIDTH  = 5,
   parameter int          TCAM_ADDR_WIDTH    = 6,
   parameter int          METER_COUNTER_SIZE = 32,
   parameter int          QUEUE_DEPTH        = 4,
   parameter logic [31:0] BEAT_MARKER        = BEAT_MARKER_DEFAULT
) (
   input  logic                                 dpl_clk,
   input  logic                                 dpl_reset,
   input  logic [DPL_PKT_BIT_WIDTH-1:0]         dpl_pkt_header_out_i,
   input  logic                                 dpl_pkt_header_out_enable_i,
   input  logic                                 dpl_of_table_missed_i,
   input  logic [TCAM_ADDR_WIDTH-1:0]           dpl_flow_addr_i,
   input  logic [OF_FLOW_TAG_WIDTH-1:0]         dpl_flow_tag_i,
   input  logic [METER_COUNTER_SIZE-1:0]        dpl_flow_count_i,
   output logic [FIFO_DATA_WIDTH-1:0]           egress_dpl_data_o,
   output logic                                 egress_dpl_wr_en_o,
   input  logic                                 egress_dpl_full_i,
   output logic [31:0]                          egr_pkt_count_o,
   output logic [31:0]                          egr_drop_count_o,
   output logic [$clog2(QUEUE_DEPTH+1)-1:0]     egr_queue_level_o,
   output logic                                 egr_busy_o
);

   localparam int W        = FIFO_DATA_WIDTH;
   localparam int HU       = hdr_upper_w(DPL_PKT_BIT_WIDTH, PAYLOAD_BEATS, W);
   localparam int HDR_LO   = meta_hdr_lo();
   localparam int CNT_LO   = meta_count_lo(HU);
   localparam int TAG_LO   = meta_tag_lo(HU);
   localparam int ADDR_LO  = meta_addr_lo(HU);
   localparam int MISS_BIT = meta_miss_bit(HU);
   localparam int META_END = meta_end(HU);
   localparam int IDX_W    = $clog2(PAYLOAD_BEATS + 1);
   localparam int LVL_W    = $clog2(QUEUE_DEPTH + 1);

   typedef struct packed {
      logic [DPL_PKT_BIT_WIDTH-1:0] hdr;
      egr_result_t                  res;
   } bundle_t;

   typedef enum logic [1:0] {
      IDLE,
      META,
      PAY
   } state_t;

   if (HU < 0) begin : g_hu_err
      $error("netwalk_dpl_egress_packer: header narrower than the payload beats");
   end
   if (META_END > W - MARKER_W) begin : g_meta_err
      $error("netwalk_dpl_egress_packer: metadata fields overlap the top marker");
   end
   if ((OF_FLOW_TAG_WIDTH > TAG_W) || (TCAM_ADDR_WIDTH > ADDR_W) ||
       (METER_COUNTER_SIZE > COUNT_W) || (PAYLOAD_BEATS < 1)) begin : g_field_err
      $error("netwalk_dpl_egress_packer: sideband field wider than its metadata slot");
   end

   bundle_t          in_bundle;
   bundle_t          head;
   logic             push_ok;
   logic             pop;
   logic             wr_en;
   logic             last_beat;
   logic             more;
   logic [LVL_W-1:0] level;
   state_t           state;
   logic [IDX_W-1:0] beat_idx;
   logic [W-1:0]     meta_beat;
   logic [W-1:0]     beat_data;
   logic [31:0]      pkt_count;
   logic [31:0]      drop_count;

   // Widen the sideband fields once at capture so the queue stores them ready to emit
   always_comb begin
      in_bundle            = '0;
      in_bundle.hdr        = dpl_pkt_header_out_i;
      in_bundle.res.missed = dpl_of_table_missed_i;
      in_bundle.res.addr   = ADDR_W'(dpl_flow_addr_i);
      in_bundle.res.tag    = TAG_W'(dpl_flow_tag_i);
      in_bundle.res.count  = COUNT_W'(dpl_flow_count_i);
   end

   netwalk_egr_result_fifo #(
      .WIDTH   ($bits(bundle_t)),
      .DEPTH   (QUEUE_DEPTH),
      .LEVEL_W (LVL_W)
   ) u_result_fifo (
      .clk      (dpl_clk),
      .reset    (dpl_reset),
      .push     (dpl_pkt_header_out_enable_i),
      .pop      (pop),
      .din      (in_bundle),
      .head     (head),
      .accepted (push_ok),
      .level    (level)
   );

   // A beat is written whenever one is pending and the FIFO has room; reset cuts it off at once
   assign wr_en     = (state != IDLE) && !egress_dpl_full_i && !dpl_reset;
   assign last_beat = (beat_idx == IDX_W'(PAYLOAD_BEATS));
   assign pop       = (state == PAY) && wr_en && last_beat;
   // Queue still holds a result after this cycle's pop (counting a same-cycle push)
   assign more      = (level > LVL_W'(1)) || push_ok;

   // Emission sequencer: metadata beat, then payload beats, chaining straight into the next result
   always_ff @(posedge dpl_clk) begin
      if (dpl_reset) begin
         state    <= IDLE;
         beat_idx <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (push_ok) begin
                  state <= META;
               end
            end
            META: begin
               if (wr_en) begin
                  state    <= PAY;
                  beat_idx <= IDX_W'(1);
               end
            end
            PAY: begin
               if (wr_en) begin
                  if (last_beat) begin
                     beat_idx <= '0;
                     state    <= more ? META : IDLE;
                  end else begin
                     beat_idx <= beat_idx + IDX_W'(1);
                  end
               end
            end
            default: begin
               state    <= IDLE;
               beat_idx <= '0;
            end
         endcase
      end
   end

   // Metadata beat: markers at both ends, overflow header bits, then sideband fields
   always_comb begin
      meta_beat                      = '0;
      meta_beat[MARKER_W-1:0]        = BEAT_MARKER;
      meta_beat[W-1 -: MARKER_W]     = BEAT_MARKER;
      for (int i = 0; i < HU; i++) begin
         meta_beat[HDR_LO + i] = head.hdr[PAYLOAD_BEATS * W + i];
      end
      meta_beat[CNT_LO +: COUNT_W]   = head.res.count;
      meta_beat[TAG_LO +: TAG_W]     = head.res.tag;
      meta_beat[ADDR_LO +: ADDR_W]   = head.res.addr;
      meta_beat[MISS_BIT]            = head.res.missed;
   end

   // Select the current beat of the head result: index 0 is metadata, k>0 is header slice k-1
   always_comb begin
      beat_data = meta_beat;
      for (int k = 0; k < PAYLOAD_BEATS; k++) begin
         if (beat_idx == IDX_W'(k + 1)) begin
            beat_data = head.hdr[k * W +: W];
         end
      end
   end

   // Saturating result counters: completed emissions and refused captures
   always_ff @(posedge dpl_clk) begin
      if (dpl_reset) begin
         pkt_count  <= '0;
         drop_count <= '0;
      end else begin
         if (pop && (pkt_count != 32'hffffffff)) begin
            pkt_count <= pkt_count + 32'd1;
         end
         if (dpl_pkt_header_out_enable_i && !push_ok && (drop_count != 32'hffffffff)) begin
            drop_count <= drop_count + 32'd1;
         end
      end
   end

   assign egress_dpl_data_o  = beat_data;
   assign egress_dpl_wr_en_o = wr_en;
   assign egr_pkt_count_o    = pkt_count;
   assign egr_drop_count_o   = drop_count;
   assign egr_queue_level_o  = level;
   assign egr_busy_o         = (state != IDLE) || (level != '0);

endmodule

// File: tb/tb_netwalk_dpl_egress_packer.sv
// Bench for the egress packer: default configuration plus a two-payload-beat variant.
// Latency: expects the first beat one cycle after capture.
// Backpressure: exercises egress full stalls and queue overflow drops.
module tb_netwalk_dpl_egress_packer;

   localparam int          W  = 512;
   localparam logic [31:0] MK = 32'hcccccccc;

   typedef struct packed {
      logic [1099:0] hdr;
      logic          miss;
      logic [7:0]    addr;
      logic [7:0]    tag;
      logic [31:0]   cnt;
   } res_t;

   logic          clk = 1'b0;
   logic          rst;

   logic [607:0]  a_hdr;
   logic          a_en, a_miss, a_full;
   logic [5:0]    a_addr;
   logic [4:0]    a_tag;
   logic [31:0]   a_cnt;
   logic [511:0]  a_data;
   logic          a_wr, a_busy;
   logic [31:0]   a_pkt, a_drop;
   logic [2:0]    a_lvl;

   logic [1099:0] b_hdr;
   logic          b_en, b_miss, b_full;
   logic [5:0]    b_addr;
   logic [4:0]    b_tag;
   logic [31:0]   b_cnt;
   logic [511:0]  b_data;
   logic          b_wr, b_busy;
   logic [31:0]   b_pkt, b_drop;
   logic [2:0]    b_lvl;

   int checks = 0;
   int errors = 0;

   // Reference model state
   res_t         mq[$];
   int           mb = 0;
   logic [31:0]  m_pkt = '0;
   logic [31:0]  m_drop = '0;
   logic [511:0] bq[$];
   res_t         a_cur, b_cur, r;

   always #5 clk = ~clk;

   netwalk_dpl_egress_packer u_dut_a (
      .dpl_clk                     (clk),
      .dpl_reset                   (rst),
      .dpl_pkt_header_out_i        (a_hdr),
      .dpl_pkt_header_out_enable_i (a_en),
      .dpl_of_table_missed_i       (a_miss),
      .dpl_flow_addr_i             (a_addr),
      .dpl_flow_tag_i              (a_tag),
      .dpl_flow_count_i            (a_cnt),
      .egress_dpl_data_o           (a_data),
      .egress_dpl_wr_en_o          (a_wr),
      .egress_dpl_full_i           (a_full),
      .egr_pkt_count_o             (a_pkt),
      .egr_drop_count_o            (a_drop),
      .egr_queue_level_o           (a_lvl),
      .egr_busy_o                  (a_busy)
   );

   netwalk_dpl_egress_packer #(
      .DPL_PKT_BIT_WIDTH (1100),
      .PAYLOAD_BEATS     (2)
   ) u_dut_b (
      .dpl_clk                     (clk),
      .dpl_reset                   (rst),
      .dpl_pkt_header_out_i        (b_hdr),
      .dpl_pkt_header_out_enable_i (b_en),
      .dpl_of_table_missed_i       (b_miss),
      .dpl_flow_addr_i             (b_addr),
      .dpl_flow_tag_i              (b_tag),
      .dpl_flow_count_i            (b_cnt),
      .egress_dpl_data_o           (b_data),
      .egress_dpl_wr_en_o          (b_wr),
      .egress_dpl_full_i           (b_full),
      .egr_pkt_count_o             (b_pkt),
      .egr_drop_count_o            (b_drop),
      .egr_queue_level_o           (b_lvl),
      .egr_busy_o                  (b_busy)
   );

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Beat k of a result as laid out on the egress bus
   function automatic logic [511:0] beat_of(input res_t x, input int k, input int pkt_w, input int pb);
      logic [511:0] b;
      int hu;
      b = '0;
      if (k == 0) begin
         hu = pkt_w - pb * W;
         b[31:0]    = MK;
         b[511:480] = MK;
         for (int i = 0; i < hu; i++) b[32 + i] = x.hdr[pb * W + i];
         b[32 + hu +: 32] = x.cnt;
         b[64 + hu +: 8]  = x.tag;
         b[72 + hu +: 8]  = x.addr;
         b[80 + hu]       = x.miss;
      end else begin
         b = x.hdr[(k - 1) * W +: W];
      end
      return b;
   endfunction

   function automatic res_t rand_res(input int pkt_w);
      res_t x;
      x = '0;
      for (int i = 0; i < pkt_w; i++) x.hdr[i] = 1'($urandom_range(1));
      x.miss = 1'($urandom_range(1));
      x.addr = 8'($urandom_range(63));
      x.tag  = 8'($urandom_range(31));
      x.cnt  = $urandom;
      return x;
   endfunction

   task automatic drive_a(input res_t x);
      a_cur  = x;
      a_hdr  = x.hdr[607:0];
      a_miss = x.miss;
      a_addr = x.addr[5:0];
      a_tag  = x.tag[4:0];
      a_cnt  = x.cnt;
   endtask

   // One clock: compare DUT outputs with the model mid-cycle, then advance the model across the edge
   task automatic tick();
      logic exp_wr, exp_bwr;
      @(negedge clk);
      exp_wr = (mq.size() > 0) && !a_full && !rst;
      chk("a_wr_en", a_wr, exp_wr);
      if (exp_wr) chk("a_beat", a_data, beat_of(mq[0], mb, 608, 1));
      chk("a_level", a_lvl, mq.size());
      chk("a_busy", a_busy, mq.size() > 0);
      chk("a_pkt_count", a_pkt, m_pkt);
      chk("a_drop_count", a_drop, m_drop);
      exp_bwr = (bq.size() > 0) && !rst;
      chk("b_wr_en", b_wr, exp_bwr);
      if (exp_bwr) chk("b_beat", b_data, bq[0]);
      if (rst) begin
         mq.delete();
         bq.delete();
         mb     = 0;
         m_pkt  = '0;
         m_drop = '0;
      end else begin
         if (exp_wr) begin
            if (mb == 1) begin
               void'(mq.pop_front());
               mb = 0;
               if (m_pkt != 32'hffffffff) m_pkt++;
            end else begin
               mb++;
            end
         end
         if (a_en) begin
            if (mq.size() < 4) mq.push_back(a_cur);
            else if (m_drop != 32'hffffffff) m_drop++;
         end
         if (exp_bwr) void'(bq.pop_front());
         if (b_en) for (int k = 0; k < 3; k++) bq.push_back(beat_of(b_cur, k, 1100, 2));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int n = 0; n < 60 && (mq.size() > 0 || bq.size() > 0); n++) tick();
      tick();
   endtask

   initial begin
      logic [511:0] exp0;
      rst = 1'b1;
      a_en = 1'b0; a_full = 1'b0; b_en = 1'b0; b_full = 1'b0;
      drive_a('0);
      b_cur = '0; b_hdr = '0; b_miss = 1'b0; b_addr = '0; b_tag = '0; b_cnt = '0;
      repeat (2) @(posedge clk);
      #1;
      tick();
      rst = 1'b0;

      // Single result with the documented field values
      r = '0;
      r.hdr[607:512] = {3{32'hA5A5A5A5}};
      r.hdr[511:0]   = 512'h1234;
      r.miss = 1'b1; r.addr = 8'h2A; r.tag = 8'h13; r.cnt = 32'd7;
      drive_a(r);
      a_en = 1'b1;
      tick();
      a_en = 1'b0;
      exp0 = {32'hcccccccc, 303'd0, 1'b1, 8'h2A, 8'h13, 32'd7, {3{32'hA5A5A5A5}}, 32'hcccccccc};
      chk("single_wr0", a_wr, 1'b1);
      chk("single_beat0", a_data, exp0);
      tick();
      chk("single_wr1", a_wr, 1'b1);
      chk("single_beat1", a_data, 512'h1234);
      tick();
      chk("single_pkt", a_pkt, 32'd1);
      chk("single_idle", a_wr, 1'b0);

      // Back-pressure for 5 cycles between the metadata and payload beats
      r = rand_res(608);
      drive_a(r);
      a_en = 1'b1;
      tick();
      a_en = 1'b0;
      tick();
      a_full = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_hold_data", a_data, beat_of(r, 1, 608, 1));
         tick();
      end
      a_full = 1'b0;
      drain();
      chk("bp_pkt", a_pkt, 32'd2);

      // Overflow: six captures while egress is full
      a_full = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive_a(rand_res(608));
         a_en = 1'b1;
         tick();
      end
      a_en = 1'b0;
      tick();
      chk("ovf_level", a_lvl, 3'd4);
      chk("ovf_drop", a_drop, 32'd2);
      a_full = 1'b0;
      drain();
      chk("ovf_pkt", a_pkt, 32'd6);

      // Captures against a full queue while it drains: accepted only on pop cycles
      a_full = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive_a(rand_res(608));
         a_en = 1'b1;
         tick();
      end
      a_full = 1'b0;
      for (int i = 0; i < 6; i++) begin
         drive_a(rand_res(608));
         a_en = 1'b1;
         tick();
      end
      a_en = 1'b0;
      drain();

      // Random traffic with random stalls
      for (int i = 0; i < 400; i++) begin
         a_full = ($urandom_range(3) == 0);
         a_en   = ($urandom_range(2) == 0);
         drive_a(rand_res(608));
         tick();
      end
      a_en = 1'b0;
      a_full = 1'b0;
      drain();

      // Reset right after a metadata beat abandons the packet
      drive_a(rand_res(608));
      a_en = 1'b1;
      tick();
      a_en = 1'b0;
      tick();
      rst = 1'b1;
      #1;
      chk("rst_wr_forced", a_wr, 1'b0);
      tick();
      rst = 1'b0;
      chk("rst_level", a_lvl, 3'd0);
      chk("rst_pkt", a_pkt, 32'd0);
      chk("rst_drop", a_drop, 32'd0);
      chk("rst_busy", a_busy, 1'b0);
      r = rand_res(608);
      drive_a(r);
      a_en = 1'b1;
      tick();
      a_en = 1'b0;
      chk("rst_new_meta", a_data, beat_of(r, 0, 608, 1));
      drain();

      // Two payload beats, 1100-bit header
      b_cur  = rand_res(1100);
      b_hdr  = b_cur.hdr;
      b_miss = b_cur.miss;
      b_addr = b_cur.addr[5:0];
      b_tag  = b_cur.tag[4:0];
      b_cnt  = b_cur.cnt;
      b_en = 1'b1;
      tick();
      b_en = 1'b0;
      chk("b_meta_hdr_top", b_data[107:32], 512'(b_cur.hdr[1099:1024]));
      chk("b_meta_count", b_data[139:108], b_cur.cnt);
      tick();
      chk("b_pay0", b_data, b_cur.hdr[511:0]);
      tick();
      chk("b_pay1", b_data, b_cur.hdr[1023:512]);
      tick();
      chk("b_pkt", b_pkt, 32'd1);
      chk("b_idle", b_wr, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
